qpu_dtcm_icb_arbiter: RTL

- Two-requester ICB arbiter in front of the DTCM controller's single ICB port.
- Requester 0 is the LSU (load/store instructions). Requester 1 is the measurement-result writer, which stores MCU measurement words into DTCM.
- Round-robin grant with hold-while-stalled. An ID FIFO tracks outstanding commands so each response returns to the requester that issued its command.

---
 rtl/qpu_dtcm_icb_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/qpu_dtcm_icb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qpu_dtcm_icb_arbiter
// Description : Two-requester round-robin ICB arbiter (LSU, measurement writer)
//               in front of the DTCM port, with an ID FIFO for response routing.
// Revision    : 1.0 - initial release
// ============================================================================
module qpu_dtcm_icb_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int OST_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // requester 0 (LSU)
  input  logic                         r0_cmd_valid,
  output logic                         r0_cmd_ready,
  input  logic [AW-1:0]                r0_cmd_addr,
  input  logic                         r0_cmd_read,
  input  logic [DW-1:0]                r0_cmd_wdata,
  input  logic [DW/8-1:0]              r0_cmd_wmask,
  output logic                         r0_rsp_valid,
  input  logic                         r0_rsp_ready,
  output logic [DW-1:0]                r0_rsp_rdata,
  // requester 1 (measurement-result writer)
  input  logic                         r1_cmd_valid,
  output logic                         r1_cmd_ready,
  input  logic [AW-1:0]                r1_cmd_addr,
  input  logic                         r1_cmd_read,
  input  logic [DW-1:0]                r1_cmd_wdata,
  input  logic [DW/8-1:0]              r1_cmd_wmask,
  output logic                         r1_rsp_valid,
  input  logic                         r1_rsp_ready,
  output logic [DW-1:0]                r1_rsp_rdata,
  // DTCM controller side
  output logic                         o_cmd_valid,
  input  logic                         o_cmd_ready,
  output logic [AW-1:0]                o_cmd_addr,
  output logic                         o_cmd_read,
  output logic [DW-1:0]                o_cmd_wdata,
  output logic [DW/8-1:0]              o_cmd_wmask,
  input  logic                         o_rsp_valid,
  output logic                         o_rsp_ready,
  input  logic [DW-1:0]                o_rsp_rdata,
  // status
  output logic [$clog2(OST_DEPTH):0]   ost_cnt,
  output logic                         err_orphan_rsp
);

  localparam int c_PW = $clog2(OST_DEPTH);
  localparam int c_CW = $clog2(OST_DEPTH) + 1;

  logic              r_rr_last;
  logic              r_lock_vld;
  logic              r_lock_id;
  logic              r_ids [OST_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_CW-1:0]   r_cnt;
  logic              r_err;

  logic w_full;
  logic w_empty;
  logic w_gnt_vld;
  logic w_gnt_id;
  logic w_sel_valid;
  logic w_push;
  logic w_stall;
  logic w_head;
  logic w_pop;
  logic w_orphan;

  assign w_full  = (r_cnt == c_CW'(OST_DEPTH));
  assign w_empty = (r_cnt == '0);

  // A stalled command locks the grant so the presented fields cannot switch.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (r_lock_vld) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (r0_cmd_valid && r1_cmd_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = ~r_rr_last;
    end else if (r0_cmd_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (r1_cmd_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  assign w_sel_valid  = w_gnt_id ? r1_cmd_valid : r0_cmd_valid;
  assign o_cmd_valid  = w_gnt_vld & w_sel_valid & ~w_full;
  assign o_cmd_addr   = w_gnt_id ? r1_cmd_addr  : r0_cmd_addr;
  assign o_cmd_read   = w_gnt_id ? r1_cmd_read  : r0_cmd_read;
  assign o_cmd_wdata  = w_gnt_id ? r1_cmd_wdata : r0_cmd_wdata;
  assign o_cmd_wmask  = w_gnt_id ? r1_cmd_wmask : r0_cmd_wmask;

  assign r0_cmd_ready = w_gnt_vld & ~w_gnt_id & o_cmd_ready & ~w_full;
  assign r1_cmd_ready = w_gnt_vld &  w_gnt_id & o_cmd_ready & ~w_full;

  assign w_push  = o_cmd_valid & o_cmd_ready;
  assign w_stall = o_cmd_valid & ~o_cmd_ready;

  // Responses follow the FIFO head; with nothing outstanding they are absorbed.
  assign w_head       = r_ids[r_rd_ptr];
  assign r0_rsp_valid = o_rsp_valid & ~w_empty & ~w_head;
  assign r1_rsp_valid = o_rsp_valid & ~w_empty &  w_head;
  assign r0_rsp_rdata = o_rsp_rdata;
  assign r1_rsp_rdata = o_rsp_rdata;
  assign o_rsp_ready  = w_empty ? 1'b1 : (w_head ? r1_rsp_ready : r0_rsp_ready);
  assign w_pop        = o_rsp_valid & o_rsp_ready & ~w_empty;
  assign w_orphan     = o_rsp_valid & w_empty;

  assign ost_cnt        = r_cnt;
  assign err_orphan_rsp = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_last  <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) begin
        r_ids[r_wr_ptr] <= w_gnt_id;
        r_wr_ptr        <= r_wr_ptr + c_PW'(1);
        r_rr_last       <= w_gnt_id;
        r_lock_vld      <= 1'b0;
      end else if (w_stall) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_gnt_id;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
